// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus slave port: FSM states and default widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bus_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_BURST_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    BURST,
    WDATA,
    RREQ,
    RWAIT,
    RDATA,
    DONE
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// Shift register, LSB first: serial-in fills from the MSB end, serial-out is bit 0.
// Latency: one clk per shift or parallel load.
// Backpressure: none; shifts only when shift_en is high, load wins over shift.
//
// Ports: clk/reset (sync, active-high), load + load_data (parallel in),
//        shift_en + shift_in (serial in), data (parallel out, data[0] = serial out).
module bus_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         shift_in,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift_en) begin
      data <= {shift_in, data[W-1:1]};
    end
  end

endmodule

// File: rtl/bus_slave_port.sv
// Serial bus slave: collects address, burst length and write words from a bit stream, drives
// word-wide memory strobes/requests and serialises read words back to the master.
// Latency: wr_strobe one cycle after the last write bit; rd_req one cycle after the burst field.
// Backpressure: slave_ready gates rx bits; master_ready=0 holds tx_bit; slave_busy blocks start.
//
// Ports: clk, reset (sync, active-high); write_enable/read_enable select the transaction;
//        rx_bit/master_valid/slave_ready serial in; address/wdata/wr_strobe/rd_req memory side;
//        rd_data/rd_valid memory return; tx_bit/tx_valid/master_ready serial out; done pulse.
module bus_slave_port
  import bus_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic              read_enable,
  input  logic              rx_bit,
  input  logic              master_valid,
  output logic              slave_ready,
  input  logic              slave_busy,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wdata,
  output logic              wr_strobe,
  output logic              rd_req,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic              tx_bit,
  output logic              tx_valid,
  input  logic              master_ready,
  output logic              done
);

  localparam int MAXW = max3(ADDR_W, BURST_W, DATA_W);
  localparam int CW   = $clog2(MAXW + 1);
  localparam int BW   = BURST_W + 1;

  localparam logic [CW-1:0] ADDR_LAST  = CW'(ADDR_W - 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_W - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_W - 1);

  state_t              state;
  logic                mode_wr;
  logic [CW-1:0]       bit_cnt;
  logic [BW-1:0]       beat_cnt;
  logic [BW-1:0]       beat_total;
  logic [MAXW-1:0]     rx_q;
  logic [MAXW-1:0]     rx_next;
  logic [BURST_W-1:0]  burst_field;
  logic [DATA_W-1:0]   tx_q;
  logic                rx_hs;
  logic                enable_held;
  logic                tx_load;
  logic                tx_shift;
  logic                last_beat;
  logic                unused_bits;

  assign rx_hs       = master_valid & slave_ready;
  // Fields arrive LSB first into the MSB end, so after k bits the field is the top k bits.
  assign rx_next     = {rx_bit, rx_q[MAXW-1:1]};
  assign burst_field = rx_next[MAXW-1 -: BURST_W];
  assign enable_held = mode_wr ? write_enable : read_enable;
  assign tx_load     = (state == RWAIT) & rd_valid & enable_held;
  assign tx_shift    = tx_valid & master_ready;
  assign last_beat   = (beat_cnt + BW'(1)) == beat_total;
  assign tx_bit      = tx_valid & tx_q[0];
  // Bits shifted out of the rx register and the parallel view of tx are not needed.
  assign unused_bits = ^{rx_q[0], tx_q};

  bus_shift_reg #(.W(MAXW)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .load_data ({MAXW{1'b0}}),
    .shift_en  (rx_hs),
    .shift_in  (rx_bit),
    .data      (rx_q)
  );

  bus_shift_reg #(.W(DATA_W)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .load      (tx_load),
    .load_data (rd_data),
    .shift_en  (tx_shift),
    .shift_in  (1'b0),
    .data      (tx_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mode_wr     <= 1'b0;
      bit_cnt     <= '0;
      beat_cnt    <= '0;
      beat_total  <= '0;
      address     <= '0;
      wdata       <= '0;
      slave_ready <= 1'b0;
      wr_strobe   <= 1'b0;
      rd_req      <= 1'b0;
      tx_valid    <= 1'b0;
      done        <= 1'b0;
    end else if (state != IDLE && !enable_held) begin
      // Master withdrew its enable: drop everything without issuing any further pulse.
      state       <= IDLE;
      bit_cnt     <= '0;
      beat_cnt    <= '0;
      address     <= '0;
      wdata       <= '0;
      slave_ready <= 1'b0;
      wr_strobe   <= 1'b0;
      rd_req      <= 1'b0;
      tx_valid    <= 1'b0;
      done        <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      rd_req    <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if ((write_enable ^ read_enable) && !slave_busy) begin
            mode_wr     <= write_enable;
            state       <= ADDR;
            slave_ready <= 1'b1;
            bit_cnt     <= '0;
            beat_cnt    <= '0;
          end
        end
        ADDR: begin
          if (rx_hs) begin
            if (bit_cnt == ADDR_LAST) begin
              address <= rx_next[MAXW-1 -: ADDR_W];
              bit_cnt <= '0;
              state   <= BURST;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        BURST: begin
          if (rx_hs) begin
            if (bit_cnt == BURST_LAST) begin
              // A zero-length burst still moves one beat.
              beat_total <= (burst_field == '0) ? BW'(1) : {1'b0, burst_field};
              bit_cnt    <= '0;
              if (mode_wr) begin
                state <= WDATA;
              end else begin
                state       <= RREQ;
                slave_ready <= 1'b0;
                rd_req      <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        WDATA: begin
          if (wr_strobe) begin
            // Strobe cycle: rx is paused so the beat bookkeeping never overlaps a bit.
            address  <= address + ADDR_W'(1);
            beat_cnt <= beat_cnt + BW'(1);
            if (last_beat) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              slave_ready <= 1'b1;
            end
          end else if (rx_hs) begin
            if (bit_cnt == DATA_LAST) begin
              wdata       <= rx_next[MAXW-1 -: DATA_W];
              wr_strobe   <= 1'b1;
              slave_ready <= 1'b0;
              bit_cnt     <= '0;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        RREQ: begin
          state <= RWAIT;
        end
        RWAIT: begin
          if (rd_valid) begin
            state    <= RDATA;
            tx_valid <= 1'b1;
            bit_cnt  <= '0;
          end
        end
        RDATA: begin
          if (master_ready) begin
            if (bit_cnt == DATA_LAST) begin
              tx_valid <= 1'b0;
              address  <= address + ADDR_W'(1);
              beat_cnt <= beat_cnt + BW'(1);
              if (last_beat) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state  <= RREQ;
                rd_req <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_slave_port.sv
// Bench for bus_slave_port: directed vector table, hand-written corner sequences and random
// transactions checked against a transaction-level model (expected strobes / serial bytes).
// Memory side is a simple array with a random 1..3 cycle read latency.
module tb_bus_slave_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic        rx_bit = 1'b0;
  logic        master_valid = 1'b0;
  logic        slave_busy = 1'b0;
  logic [7:0]  rd_data = '0;
  logic        rd_valid = 1'b0;
  logic        master_ready = 1'b0;
  logic        slave_ready;
  logic [11:0] address;
  logic [7:0]  wdata;
  logic        wr_strobe;
  logic        rd_req;
  logic        tx_bit;
  logic        tx_valid;
  logic        done;

  always #5 clk = ~clk;

  bus_slave_port dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .rx_bit       (rx_bit),
    .master_valid (master_valid),
    .slave_ready  (slave_ready),
    .slave_busy   (slave_busy),
    .address      (address),
    .wdata        (wdata),
    .wr_strobe    (wr_strobe),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .tx_bit       (tx_bit),
    .tx_valid     (tx_valid),
    .master_ready (master_ready),
    .done         (done)
  );

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [11:0] n;
    int          mv;        // 0 always valid, 1 toggled, 2 random
    int          mr;        // 0 master_ready always, 1 random
    logic [31:0] dat;       // byte i = beat i
    logic [11:0] exp_last;  // address of the last beat
    logic [15:0] exp_bits;  // read: first 16 tx bits, bit 0 sent first
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          mr_mode = 0;
  logic [7:0]  mem [4096];
  logic [11:0] str_addr_q [$];
  logic [7:0]  str_dat_q [$];
  logic [11:0] rd_addr_q [$];
  bit          tx_q [$];
  int          str_cyc_last = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  vec_t        vt [6];
  int          dur [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Memory: answer each rd_req after 1..3 cycles with the word at the requested address.
  initial begin : mem_model
    int          cnt;
    logic [11:0] ra;
    cnt = 0;
    ra  = '0;
    forever begin
      @(posedge clk);
      #1;
      rd_valid = 1'b0;
      if (reset) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          rd_valid = 1'b1;
          rd_data  = mem[ra];
        end
      end
      if (rd_req) begin
        rd_addr_q.push_back(address);
        ra  = address;
        cnt = $urandom_range(1, 3);
      end
    end
  end

  initial begin : master_ready_gen
    forever begin
      @(posedge clk);
      #1;
      master_ready = (mr_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  initial begin : monitor
    bit prev_hold;
    bit prev_bit;
    prev_hold = 1'b0;
    prev_bit  = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_strobe) begin
        str_addr_q.push_back(address);
        str_dat_q.push_back(wdata);
        str_cyc_last = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (tx_valid && prev_hold) check("tx_hold", 32'(tx_bit), 32'(prev_bit));
      if (tx_valid && master_ready) tx_q.push_back(tx_bit);
      prev_hold = tx_valid && !master_ready;
      prev_bit  = tx_bit;
    end
  end

  task automatic clear_logs();
    str_addr_q.delete();
    str_dat_q.delete();
    rd_addr_q.delete();
    tx_q.delete();
    done_cnt = 0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int nbits, input int mv);
    for (int i = 0; i < nbits; i++) begin
      bit hs;
      int g;
      hs = 1'b0;
      g  = 0;
      while (!hs && g < 100) begin
        rx_bit = v[i];
        case (mv)
          0:       master_valid = 1'b1;
          1:       master_valid = (g % 2 == 1);
          default: master_valid = 1'($urandom_range(0, 1));
        endcase
        hs = master_valid & slave_ready;
        step();
        g++;
      end
      if (!hs) begin
        n_cmp++;
        n_bad++;
        $display("FAIL hs_timeout: bit %0d never accepted (cycle %0d)", i, cyc);
      end
    end
    master_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (!slave_ready && g < 20) begin
      step();
      g++;
    end
    check("start_ready", 32'(slave_ready), 1);
  endtask

  task automatic do_txn(input bit wr, input logic [11:0] addr, input logic [11:0] n,
                        input int mv, input logic [31:0] dat, output int d);
    int          nb;
    int          t0;
    int          g;
    logic [11:0] ea;
    nb = (n == 0) ? 1 : int'(n);
    clear_logs();
    write_enable = wr;
    read_enable  = !wr;
    wait_ready();
    t0 = cyc;
    send_bits(32'(addr), 12, mv);
    send_bits(32'(n), 12, mv);
    if (wr) begin
      for (int i = 0; i < nb; i++) begin
        send_bits(32'(dat[8*(i%4) +: 8]), 8, mv);
        ea = addr + 12'(i);
        check("strobe_latency", 32'(wr_strobe), 1);
        check("strobe_addr", 32'(address), 32'(ea));
        check("strobe_wdata", 32'(wdata), 32'(dat[8*(i%4) +: 8]));
      end
    end
    g = 0;
    while (!done && g < 600) begin
      step();
      g++;
    end
    check("done_seen", 32'(done), 1);
    d = cyc - t0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    step();
    step();
  endtask

  // Transaction-level expectation: max(N,1) beats at consecutive wrapped addresses.
  task automatic verify(input bit wr, input logic [11:0] addr, input logic [11:0] n,
                        input logic [31:0] dat);
    int          nb;
    logic [11:0] ea;
    logic [7:0]  got;
    nb = (n == 0) ? 1 : int'(n);
    check("done_count", done_cnt, 1);
    if (wr) begin
      check("strobe_count", str_addr_q.size(), nb);
      check("rd_req_count_wr", rd_addr_q.size(), 0);
      for (int i = 0; i < nb && i < str_addr_q.size(); i++) begin
        ea = addr + 12'(i);
        check("log_strobe_addr", 32'(str_addr_q[i]), 32'(ea));
        check("log_strobe_data", 32'(str_dat_q[i]), 32'(dat[8*(i%4) +: 8]));
      end
      check("done_after_strobe", 32'(done_cyc > str_cyc_last), 1);
    end else begin
      check("rd_req_count", rd_addr_q.size(), nb);
      check("strobe_count_rd", str_addr_q.size(), 0);
      check("tx_length", tx_q.size(), nb * 8);
      for (int i = 0; i < nb; i++) begin
        ea = addr + 12'(i);
        if (i < rd_addr_q.size()) check("rd_addr", 32'(rd_addr_q[i]), 32'(ea));
        got = '0;
        for (int j = 0; j < 8; j++) begin
          if (8 * i + j < tx_q.size()) got[j] = tx_q[8*i+j];
        end
        check("tx_byte", 32'(got), 32'(dat[8*(i%4) +: 8]));
      end
    end
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] g16;
    int          d;
    bit          wr;
    logic [11:0] ra;
    logic [11:0] rn;
    logic [31:0] rdat;
    int          rmv;

    vt[0] = '{1'b1, 12'h0A5, 12'd1, 0, 0, 32'h0000_003C, 12'h0A5, 16'h0000};
    vt[1] = '{1'b1, 12'hFFF, 12'd3, 0, 0, 32'h0033_2211, 12'h001, 16'h0000};
    vt[2] = '{1'b0, 12'h010, 12'd2, 0, 0, 32'h0000_5AA5, 12'h011, 16'h5AA5};
    vt[3] = '{1'b1, 12'h0A5, 12'd1, 1, 0, 32'h0000_003C, 12'h0A5, 16'h0000};
    vt[4] = '{1'b1, 12'h7FE, 12'd0, 2, 0, 32'h0000_0081, 12'h7FE, 16'h0000};
    vt[5] = '{1'b0, 12'hFFF, 12'd2, 2, 1, 32'h0000_0FF0, 12'h000, 16'h0FF0};

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    check("rst_slave_ready", 32'(slave_ready), 0);
    check("rst_address", 32'(address), 0);
    check("rst_wdata", 32'(wdata), 0);
    check("rst_pulses", 32'({wr_strobe, rd_req, done}), 0);
    check("rst_tx", 32'({tx_bit, tx_valid}), 0);
    reset = 1'b0;
    step();

    // Both enables high is not a transaction
    write_enable = 1'b1;
    read_enable  = 1'b1;
    repeat (3) step();
    check("both_enables_idle", 32'(slave_ready), 0);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    step();

    // Busy memory blocks the start; release begins ADDR
    slave_busy   = 1'b1;
    write_enable = 1'b1;
    repeat (4) step();
    check("busy_holds_idle", 32'(slave_ready), 0);
    slave_busy = 1'b0;
    step();
    check("busy_release_addr", 32'(slave_ready), 1);

    // Directed vector table
    for (int k = 0; k < 6; k++) begin
      mr_mode = vt[k].mr;
      if (!vt[k].wr) begin
        for (int i = 0; i < 4; i++) mem[vt[k].addr + 12'(i)] = vt[k].dat[8*i +: 8];
      end
      do_txn(vt[k].wr, vt[k].addr, vt[k].n, vt[k].mv, vt[k].dat, dur[k]);
      verify(vt[k].wr, vt[k].addr, vt[k].n, vt[k].dat);
      if (vt[k].wr) begin
        if (str_addr_q.size() > 0)
          check("vec_last_strobe_addr", 32'(str_addr_q[str_addr_q.size()-1]), 32'(vt[k].exp_last));
      end else begin
        if (rd_addr_q.size() > 0)
          check("vec_last_rd_addr", 32'(rd_addr_q[rd_addr_q.size()-1]), 32'(vt[k].exp_last));
        g16 = '0;
        for (int j = 0; j < 16; j++) begin
          if (j < tx_q.size()) g16[j] = tx_q[j];
        end
        check("vec_tx_bits", 32'(g16), 32'(vt[k].exp_bits));
      end
    end
    mr_mode = 0;
    // Toggling master_valid doubles each of the 32 serial bit slots.
    check("toggle_duration_delta", dur[3] - dur[0], 32);

    // Reset in the middle of a write word
    clear_logs();
    write_enable = 1'b1;
    wait_ready();
    send_bits(32'h123, 12, 0);
    send_bits(32'd2, 12, 0);
    send_bits(32'h5, 4, 0);
    reset = 1'b1;
    step();
    check("midrst_address", 32'(address), 0);
    check("midrst_wdata", 32'(wdata), 0);
    check("midrst_ctrl", 32'({slave_ready, wr_strobe, rd_req, tx_bit, tx_valid, done}), 0);
    reset        = 1'b0;
    write_enable = 1'b0;
    repeat (3) step();
    check("midrst_no_strobe", str_addr_q.size(), 0);
    check("midrst_no_done", done_cnt, 0);

    // Enable dropped during the burst field
    clear_logs();
    write_enable = 1'b1;
    wait_ready();
    send_bits(32'h456, 12, 0);
    send_bits(32'h3, 5, 0);
    write_enable = 1'b0;
    step();
    check("abort_ready", 32'(slave_ready), 0);
    check("abort_address", 32'(address), 0);
    check("abort_wdata", 32'(wdata), 0);
    repeat (3) step();
    check("abort_no_strobe", str_addr_q.size(), 0);
    check("abort_no_done", done_cnt, 0);

    // Random transactions
    for (int r = 0; r < 20; r++) begin
      wr      = 1'($urandom_range(0, 1));
      ra      = 12'($urandom);
      rn      = 12'($urandom_range(0, 4));
      rdat    = $urandom;
      rmv     = $urandom_range(0, 2);
      mr_mode = $urandom_range(0, 1);
      if (!wr) begin
        for (int i = 0; i < 4; i++) mem[ra + 12'(i)] = rdat[8*i +: 8];
      end
      do_txn(wr, ra, rn, rmv, rdat, d);
      verify(wr, ra, rn, rdat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
